// File: rtl/hilo_pkg.sv
// Shared definitions for the Hi/Lo multiply/divide unit: op encodings,
// FSM states and default datapath sizing.
package hilo_pkg;

    localparam int DEFAULT_WIDTH = 64;
    localparam int DEFAULT_CNT_W = 7;

    localparam logic [2:0] OP_NONE  = 3'b000;
    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX
    } hiloState_t;

endpackage

// File: rtl/hilo_iter_core.sv
// Bit-serial datapath: shift-add multiply and restoring divide on unsigned
// magnitudes, one bit per step, with its own iteration counter.
module hilo_iter_core #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 7
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 step,
    input  logic                 mulMode,
    input  logic [WIDTH-1:0]     loadA,
    input  logic [WIDTH-1:0]     loadB,
    output logic [2*WIDTH-1:0]   acc,
    output logic [WIDTH-1:0]     remainder,
    output logic                 lastStep
);

    logic [WIDTH-1:0] operandB;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH:0]   mulSum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;

    // Multiply: low half starts as the multiplier and drains out the bottom
    // while partial sums (with carry) shift in from the top.
    assign mulSum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operandB} : '0);
    // Divide: low half of acc is the dividend/quotient shift register.
    assign shifted  = {remainder, acc[WIDTH-1]};
    assign trial    = shifted - {1'b0, operandB};
    assign lastStep = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc       <= '0;
            remainder <= '0;
            operandB  <= '0;
            cnt       <= '0;
        end else if (load) begin
            acc       <= {{WIDTH{1'b0}}, loadA};
            remainder <= '0;
            operandB  <= loadB;
            cnt       <= '0;
        end else if (step) begin
            cnt <= lastStep ? '0 : cnt + 1'b1;
            if (mulMode) begin
                acc <= {mulSum, acc[WIDTH-1:1]};
            end else if (trial[WIDTH]) begin
                remainder        <= shifted[WIDTH-1:0];
                acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], 1'b0};
            end else begin
                remainder        <= trial[WIDTH-1:0];
                acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], 1'b1};
            end
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// EXE-stage Hi/Lo register pair with an iterative multiply/divide engine;
// stalls the pipeline while an operation is in flight.
module hilo_muldiv_unit
    import hilo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             EXE_Start,
    input  logic [2:0]       EXE_Op,
    input  logic [WIDTH-1:0] EXE_A,
    input  logic [WIDTH-1:0] EXE_B,
    input  logic             EXE_LoRead,
    input  logic             EXE_HiRead,
    output logic             Busy,
    output logic             Stall,
    output logic             Done,
    output logic [WIDTH-1:0] Lo_ReadData,
    output logic [WIDTH-1:0] Hi_ReadData
);

    hiloState_t state, nextState;
    logic loadOp, stepEn, writeResult, writeHi, writeLo;
    logic signA, signB, isMulOp, divZero, doneReg, lastStep;
    logic reqSigned, reqMul, reqDivZero, reqSignA, reqSignB;
    logic [WIDTH-1:0]   hiReg, loReg, resultHi, resultLo;
    logic [WIDTH-1:0]   absA, absB, loadA, remainder, quotient;
    logic [2*WIDTH-1:0] acc, product;

    assign reqSigned  = (EXE_Op == OP_MULT) || (EXE_Op == OP_DIV);
    assign reqMul     = (EXE_Op == OP_MULT) || (EXE_Op == OP_MULTU);
    assign reqDivZero = !reqMul && (EXE_B == '0);
    assign reqSignA   = reqSigned && EXE_A[WIDTH-1];
    assign reqSignB   = reqSigned && EXE_B[WIDTH-1];
    assign absA       = reqSignA ? -EXE_A : EXE_A;
    assign absB       = reqSignB ? -EXE_B : EXE_B;
    // A divide by zero keeps the raw dividend so it can go straight to Hi.
    assign loadA      = reqDivZero ? EXE_A : absA;

    hilo_iter_core #(.WIDTH(WIDTH), .CNT_W(CNT_W)) iterCore (
        .clock     (Clk),
        .reset     (Reset),
        .load      (loadOp),
        .step      (stepEn),
        .mulMode   (state == ST_MUL),
        .loadA     (loadA),
        .loadB     (absB),
        .acc       (acc),
        .remainder (remainder),
        .lastStep  (lastStep)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state <= ST_IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState   = state;
        loadOp      = 1'b0;
        stepEn      = 1'b0;
        writeResult = 1'b0;
        writeHi     = 1'b0;
        writeLo     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (EXE_Start) begin
                    case (EXE_Op)
                        OP_MULT, OP_MULTU: begin
                            loadOp    = 1'b1;
                            nextState = ST_MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            loadOp    = 1'b1;
                            nextState = (EXE_B == '0) ? ST_FIX : ST_DIV;
                        end
                        OP_MTHI: writeHi = 1'b1;
                        OP_MTLO: writeLo = 1'b1;
                        default: ;
                    endcase
                end
            end
            ST_MUL, ST_DIV: begin
                stepEn = 1'b1;
                if (lastStep) nextState = ST_FIX;
            end
            ST_FIX: begin
                writeResult = 1'b1;
                nextState   = ST_IDLE;
            end
            default: nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            signA   <= 1'b0;
            signB   <= 1'b0;
            isMulOp <= 1'b0;
            divZero <= 1'b0;
        end else if (loadOp) begin
            signA   <= reqSignA;
            signB   <= reqSignB;
            isMulOp <= reqMul;
            divZero <= reqDivZero;
        end
    end

    // Sign fix-up on the magnitude result; MIN/-1 falls out of this naturally.
    assign product  = (signA ^ signB) ? -acc : acc;
    assign quotient = acc[WIDTH-1:0];

    always_comb begin
        resultHi = product[2*WIDTH-1:WIDTH];
        resultLo = product[WIDTH-1:0];
        if (!isMulOp) begin
            if (divZero) begin
                resultLo = '1;
                resultHi = quotient;
            end else begin
                resultLo = (signA ^ signB) ? -quotient : quotient;
                resultHi = signA ? -remainder : remainder;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hiReg   <= '0;
            loReg   <= '0;
            doneReg <= 1'b0;
        end else begin
            doneReg <= writeResult;
            if (writeResult) begin
                hiReg <= resultHi;
                loReg <= resultLo;
            end else begin
                if (writeHi) hiReg <= EXE_A;
                if (writeLo) loReg <= EXE_A;
            end
        end
    end

    assign Busy        = (state != ST_IDLE);
    assign Stall       = Busy && (EXE_Start || EXE_LoRead || EXE_HiRead);
    assign Done        = doneReg;
    assign Hi_ReadData = hiReg;
    assign Lo_ReadData = loReg;

endmodule

// File: doc/hilo_muldiv_unit.md
Name: hilo_muldiv_unit

Overview:
Owns the architectural Hi/Lo register pair and the iterative multiply/divide engine for the EXE stage.
- Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from ID/EXE.
- Holds Hi/Lo and drives Lo_ReadData/Hi_ReadData straight into the MEM-stage data select.
- Raises Stall to the hazard unit while an operation is in flight.

Parameters:
WIDTH, 64, operand and Hi/Lo register width
CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
Clk  in  1  clock; rising edge
Reset  in  1  asynchronous, active-high reset
EXE_Start  in  1  op request valid this cycle
EXE_Op  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU, 101 MTHI, 110 MTLO, 111 reserved
EXE_A  in  WIDTH  rs operand / dividend / MTxx source
EXE_B  in  WIDTH  rt operand / divisor
EXE_LoRead  in  1  MFLO in EXE this cycle
EXE_HiRead  in  1  MFHI in EXE this cycle
Busy  out  1  engine occupied (state != IDLE)
Stall  out  1  combinational: Busy && (EXE_Start || EXE_LoRead || EXE_HiRead)
Done  out  1  one-cycle pulse after a MULT/DIV result is written
Lo_ReadData  out  WIDTH  Lo register contents
Hi_ReadData  out  WIDTH  Hi register contents

Behaviour:
- Reset:
  - Applies immediately, independent of Clk.
  - Hi=0, Lo=0, state IDLE, counter 0, Busy=0, Done=0.
  - Any in-flight op is discarded, including a reset asserted mid-iteration.
- Read path: Lo_ReadData/Hi_ReadData are the register outputs. No bypass; a write becomes visible the cycle after its capturing edge.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE, EXE_Start=1 sampled at edge E0:
  - MTHI/MTLO: Hi or Lo = EXE_A at E0. Stays IDLE, no Busy, no Done.
  - MULT/MULTU/DIV/DIVU: operands latched, transition to MUL or DIV.
  - Signed ops store |A| and |B| plus sign flags.
  - Unsigned ops store A and B raw, with sign flags cleared.
  - Op 000 or 111: no effect.
- MUL: shift-add, one bit per cycle, WIDTH cycles (edges E1..E_WIDTH), then FIX.
- DIV: restoring division, one quotient bit per cycle, WIDTH cycles, then FIX.
- Divide by zero (B==0, DIV or DIVU): skips iteration, goes IDLE→FIX at E0. Result is Lo=all ones, Hi=EXE_A unmodified. Busy for 1 cycle.
- FIX: applies sign correction, and Hi/Lo are written at the edge leaving FIX. State returns to IDLE and Done=1 for the following cycle.
  - MULT: negate the 2*WIDTH-bit product if sA^sB; Hi = upper half, Lo = lower half.
  - DIV: Lo = quotient, negated if sA^sB. Hi = remainder, negated if sA.
  - Signed MIN/-1 yields Lo=MIN, Hi=0 with no special case; absolute-value arithmetic produces it naturally.
- Latency: MULT/DIV Busy for WIDTH+1 cycles; results readable WIDTH+1 cycles after the Start cycle.
- While Busy:
  - EXE_Start is ignored; Stall holds the request upstream and the request must persist.
  - MTHI/MTLO are also stalled.
  - Hi/Lo keep their old values until FIX completes.
- Width rule: the multiply accumulator is 2*WIDTH bits. The divide partial remainder is WIDTH+1 bits.

Decomposition:
- Package hilo_pkg holds:
  - op encodings (OP_NONE..OP_MTLO)
  - FSM state enum
  - default WIDTH
- Sub-module hilo_iter_core holds the shift-add/restoring-divide datapath and iteration counter, driven by the FSM. hilo_muldiv_unit keeps the FSM, sign handling, and the Hi/Lo registers.

Test Plan:
1. Reset asserted mid-cycle (async) -> Hi=Lo=0, Busy=0, Done=0 before the next edge.
2. MULTU A=0xFFFF_FFFF_FFFF_FFFF, B=2 -> Busy 65 cycles, Done pulse; Hi=0x1, Lo=0xFFFF_FFFF_FFFF_FFFE.
3. MULT A=-3, B=5 -> Hi=0xFFFF_FFFF_FFFF_FFFF, Lo=0xFFFF_FFFF_FFFF_FFF1.
4. DIV A=-7, B=2 -> Lo=-3, Hi=-1. Then DIVU A=7, B=0 -> Busy 1 cycle, Lo=all ones, Hi=7.
5. MULT started; EXE_HiRead=1 and a second EXE_Start during Busy -> Stall=1 every busy cycle, second op not accepted, Hi unchanged until Done. Then MTLO A=0x1234 in IDLE -> Lo_ReadData=0x1234 next cycle, Busy stays 0.
6. Reset during DIV iteration 30 -> result discarded, Hi/Lo=0. A new MULTU 3*4 afterwards -> Lo=12, Hi=0.
